// File: rtl/controlador_transferencia_rolhas.sv
// Cork buffer sequencer: operator loads into the secondary buffer and batched secondary-to-main
// transfers. Define CTRL_ROLHAS_SATURACAO_EN to clamp overflowing loads instead of rejecting them.
module controlador_transferencia_rolhas #(
    parameter int unsigned MAX_CAP        = 99,
    parameter int unsigned MIN_PRINCIPAL  = 5,
    parameter int unsigned LOTE_TRANSFER  = 15,
    parameter int unsigned INIT_PRINCIPAL = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       enable,
    input  logic       consumo,
    input  logic       op_load,
    input  logic [6:0] op_qtd,
    output logic [6:0] buffer_principal,
    output logic [6:0] buffer_secundario,
    output logic       ro,
    output logic       transferindo,
    output logic       op_ack,
    output logic       op_erro,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        StOcioso    = 2'b00,
        StCarga     = 2'b01,
        StTransfere = 2'b10,
        StPausa     = 2'b11
    } estado_t;

    localparam logic [6:0] MaxCap       = 7'(MAX_CAP);
    localparam logic [6:0] MinPrincipal = 7'(MIN_PRINCIPAL);
    localparam logic [6:0] LoteTransfer = 7'(LOTE_TRANSFER);
    localparam logic [6:0] InitPrinc    = 7'(INIT_PRINCIPAL);

    estado_t    estado_q, estado_d;
    logic [6:0] main_q, main_d, sec_q, sec_d;
    logic [6:0] pend_qtd_q, pend_qtd_d, carga_qtd_q, carga_qtd_d, lote_q, lote_d;
    logic       pend_valid_q, pend_valid_d, ack_q, ack_d, erro_q, erro_d;
    logic [6:0] serve_qtd;
    logic [7:0] soma;
    logic       cabe, captura;

    always_ff @(posedge clk) begin
        if (clr) begin
            estado_q     <= StOcioso;
            main_q       <= InitPrinc;
            sec_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_qtd_q   <= '0;
            carga_qtd_q  <= '0;
            lote_q       <= '0;
            ack_q        <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            main_q       <= main_d;
            sec_q        <= sec_d;
            pend_valid_q <= pend_valid_d;
            pend_qtd_q   <= pend_qtd_d;
            carga_qtd_q  <= carga_qtd_d;
            lote_q       <= lote_d;
            ack_q        <= ack_d;
            erro_q       <= erro_d;
        end
    end

    always_comb begin
        estado_d     = estado_q;
        main_d       = main_q;
        sec_d        = sec_q;
        pend_valid_d = pend_valid_q;
        pend_qtd_d   = pend_qtd_q;
        carga_qtd_d  = carga_qtd_q;
        lote_d       = lote_q;
        ack_d        = 1'b0;
        erro_d       = 1'b0;
        serve_qtd    = '0;
        soma         = '0;
        cabe         = 1'b0;

        if (consumo && main_q != 7'd0) begin
            main_d = main_q - 7'd1;
        end

        // Outside an active OCIOSO dispatch, a load can only wait in the pending slot.
        captura = op_load && (estado_q != StOcioso || !enable);
        if (captura) begin
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_qtd_d   = op_qtd;
            end else begin
                erro_d = 1'b1;
            end
        end

        unique case (estado_q)
            StOcioso: begin
                if (!enable) begin
                    estado_d = StPausa;
                end else if (op_load || pend_valid_q) begin
                    // Older pending request goes first; a simultaneous live one refills the slot.
                    serve_qtd    = pend_valid_q ? pend_qtd_q : op_qtd;
                    pend_valid_d = pend_valid_q && op_load;
                    if (pend_valid_q && op_load) begin
                        pend_qtd_d = op_qtd;
                    end
                    soma = {1'b0, sec_q} + {1'b0, serve_qtd};
`ifdef CTRL_ROLHAS_SATURACAO_EN
                    cabe = 1'b1;
`else
                    cabe = (soma <= {1'b0, MaxCap});
`endif
                    if (cabe) begin
                        estado_d    = StCarga;
                        carga_qtd_d = serve_qtd;
                    end else begin
                        erro_d = 1'b1;
                    end
                end else if (main_q < MinPrincipal && sec_q != 7'd0) begin
                    estado_d = StTransfere;
                    lote_d   = '0;
                end
            end
            StCarga: begin
                soma     = {1'b0, sec_q} + {1'b0, carga_qtd_q};
                sec_d    = (soma > {1'b0, MaxCap}) ? MaxCap : soma[6:0];
                ack_d    = 1'b1;
                estado_d = enable ? StOcioso : StPausa;
            end
            StTransfere: begin
                if (!enable) begin
                    estado_d = StPausa;
                end else begin
                    if (main_q < MaxCap && sec_q != 7'd0) begin
                        sec_d  = sec_q - 7'd1;
                        main_d = main_d + 7'd1;
                        lote_d = lote_q + 7'd1;
                    end
                    if (lote_d >= LoteTransfer || sec_d == 7'd0 || main_d >= MaxCap) begin
                        estado_d = StOcioso;
                    end
                end
            end
            StPausa: begin
                if (enable) begin
                    estado_d = StOcioso;
                end
            end
            default: estado_d = StOcioso;
        endcase
    end

    assign buffer_principal  = main_q;
    assign buffer_secundario = sec_q;
    assign ro                = (main_q == 7'd0);
    assign transferindo      = (estado_q == StTransfere);
    assign op_ack            = ack_q;
    assign op_erro           = erro_q;
    assign estado            = estado_q;

endmodule

// File: tb/tb_controlador_transferencia_rolhas.sv
// Self-checking bench: fixed vector table, directed batch/pending/pause sequences and random
// stimulus against a behavioural model of the two cork buffers.
module tb_controlador_transferencia_rolhas;

    logic       clk = 1'b0;
    logic       clr, enable, consumo, op_load;
    logic [6:0] op_qtd;
    logic [6:0] buffer_principal, buffer_secundario;
    logic       ro, transferindo, op_ack, op_erro;
    logic [1:0] estado;

    controlador_transferencia_rolhas dut (
        .clk              (clk),
        .clr              (clr),
        .enable           (enable),
        .consumo          (consumo),
        .op_load          (op_load),
        .op_qtd           (op_qtd),
        .buffer_principal (buffer_principal),
        .buffer_secundario(buffer_secundario),
        .ro               (ro),
        .transferindo     (transferindo),
        .op_ack           (op_ack),
        .op_erro          (op_erro),
        .estado           (estado)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: counts as plain integers, pending slot as a queue of at most one entry.
    int m_main, m_sec, m_mode, m_lote, m_carga;
    int pend[$];
    bit m_ack, m_erro;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_dut();
        return {12'd0, buffer_principal, buffer_secundario, estado, op_ack, op_erro, ro,
                transferindo};
    endfunction

    function automatic logic [31:0] pack_model();
        logic [6:0] mm, ms;
        logic [1:0] md;
        mm = 7'(m_main);
        ms = 7'(m_sec);
        md = 2'(m_mode);
        return {12'd0, mm, ms, md, m_ack, m_erro, (m_main == 0), (m_mode == 2)};
    endfunction

    task automatic offer(input int q);
        if (pend.size() == 0) pend.push_back(q);
        else m_erro = 1'b1;
    endtask

    task automatic model_step(input bit c, input bit e, input bit co, input bit l, input int q);
        int nmain, nxt, srv;
        if (c) begin
            m_main = 20; m_sec = 0; m_mode = 0; m_lote = 0; m_carga = 0;
            m_ack = 0; m_erro = 0;
            pend.delete();
            return;
        end
        m_ack = 0;
        m_erro = 0;
        nmain = (co && m_main > 0) ? m_main - 1 : m_main;
        nxt = m_mode;
        if (m_mode == 0) begin
            if (!e) begin
                nxt = 3;
                if (l) offer(q);
            end else if (l || pend.size() > 0) begin
                if (pend.size() > 0) begin
                    srv = pend.pop_front();
                    if (l) pend.push_back(q);
                end else begin
                    srv = q;
                end
`ifdef CTRL_ROLHAS_SATURACAO_EN
                nxt = 1; m_carga = srv;
`else
                if (m_sec + srv <= 99) begin nxt = 1; m_carga = srv; end
                else m_erro = 1;
`endif
            end else if (m_main < 5 && m_sec > 0) begin
                nxt = 2; m_lote = 0;
            end
        end else begin
            if (l) offer(q);
            if (m_mode == 1) begin
                m_sec = (m_sec + m_carga > 99) ? 99 : m_sec + m_carga;
                m_ack = 1;
                nxt = e ? 0 : 3;
            end else if (m_mode == 2) begin
                if (!e) nxt = 3;
                else begin
                    if (m_main < 99 && m_sec > 0) begin
                        m_sec--; nmain++; m_lote++;
                    end
                    if (m_lote >= 15 || m_sec == 0 || nmain >= 99) nxt = 0;
                end
            end else if (e) begin
                nxt = 0;
            end
        end
        m_main = nmain;
        m_mode = nxt;
    endtask

    task automatic cycle(input bit c, input bit e, input bit co, input bit l, input int q);
        clr = c; enable = e; consumo = co; op_load = l; op_qtd = 7'(q);
        @(posedge clk);
        model_step(c, e, co, l, q);
        #1;
        check("model", pack_dut(), pack_model());
    endtask

    typedef struct {
        bit c, e, co, l;
        int q;
        int main, sec, st;
        bit ack, erro;
    } vec_t;

    vec_t tab[13];

    initial begin
        clr = 1'b1; enable = 1'b0; consumo = 1'b0; op_load = 1'b0; op_qtd = '0;
        //          c  e  co l  q    main sec st ack erro
        tab[0]  = '{1, 0, 0, 0, 0,   20, 0,  0, 0, 0};
        tab[1]  = '{0, 1, 0, 1, 40,  20, 0,  1, 0, 0};
        tab[2]  = '{0, 1, 0, 0, 0,   20, 40, 0, 1, 0};
        tab[3]  = '{0, 1, 1, 0, 0,   19, 40, 0, 0, 0};
        tab[4]  = '{0, 1, 1, 1, 59,  18, 40, 1, 0, 0};
        tab[5]  = '{0, 1, 0, 0, 0,   18, 99, 0, 1, 0};
`ifdef CTRL_ROLHAS_SATURACAO_EN
        tab[6]  = '{0, 1, 0, 1, 1,   18, 99, 1, 0, 0};
        tab[7]  = '{0, 0, 0, 0, 0,   18, 99, 3, 1, 0};
`else
        tab[6]  = '{0, 1, 0, 1, 1,   18, 99, 0, 0, 1};
        tab[7]  = '{0, 0, 0, 0, 0,   18, 99, 3, 0, 0};
`endif
        tab[8]  = '{0, 0, 0, 1, 5,   18, 99, 3, 0, 0};
        tab[9]  = '{0, 0, 0, 1, 3,   18, 99, 3, 0, 1};
        tab[10] = '{0, 1, 0, 0, 0,   18, 99, 0, 0, 0};
`ifdef CTRL_ROLHAS_SATURACAO_EN
        tab[11] = '{0, 1, 0, 0, 0,   18, 99, 1, 0, 0};
`else
        tab[11] = '{0, 1, 0, 0, 0,   18, 99, 0, 0, 1};
`endif
        tab[12] = '{1, 1, 0, 0, 0,   20, 0,  0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            cycle(tab[i].c, tab[i].e, tab[i].co, tab[i].l, tab[i].q);
            check($sformatf("table[%0d]", i),
                  {buffer_principal, buffer_secundario, estado, op_ack, op_erro},
                  {7'(tab[i].main), 7'(tab[i].sec), 2'(tab[i].st), tab[i].ack, tab[i].erro});
        end

        // Load 40, drain main to 4, then one full 15-cork batch.
        cycle(0, 1, 0, 1, 40);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 1, 0, 0);
        check("drained_main", 32'(buffer_principal), 32'd4);
        cycle(0, 1, 0, 0, 0);
        check("transfer_start", {30'd0, estado}, 32'd2);
        for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0, 0);
        check("batch_end", {buffer_principal, buffer_secundario, estado},
              {7'd19, 7'd25, 2'd0});

        // Batch with consumo held: main stays flat while sec drains.
        for (int i = 0; i < 15; i++) cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) cycle(0, 1, 1, 0, 0);
        check("held_consumo", {buffer_principal, buffer_secundario, estado},
              {7'd4, 7'd10, 2'd0});

        // Batch ends on empty sec; two loads mid-batch: first pending, second rejected.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 7);
        cycle(0, 1, 0, 1, 8);
        check("second_load_erro", {31'd0, op_erro}, 32'd1);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0);
        check("sec_empty_exit", {buffer_principal, buffer_secundario, estado},
              {7'd14, 7'd0, 2'd0});
        cycle(0, 1, 0, 0, 0);
        check("pending_carga", {30'd0, estado}, 32'd1);
        cycle(0, 1, 0, 0, 0);
        check("pending_applied", {buffer_secundario, op_ack}, {7'd7, 1'b1});

        // Pause mid-batch, then clr in PAUSA discards everything.
        for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 9);
        cycle(0, 0, 0, 0, 0);
        check("paused", {buffer_principal, buffer_secundario, estado}, {7'd6, 7'd5, 2'd3});
        cycle(1, 0, 0, 0, 0);
        check("clr_in_pausa", {buffer_principal, buffer_secundario, estado},
              {7'd20, 7'd0, 2'd0});
        cycle(0, 1, 0, 0, 0);
        check("pending_lost", {30'd0, estado}, 32'd0);

        // Overflow: 90 + 20.
        cycle(0, 1, 0, 1, 90);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 20);
        cycle(0, 1, 0, 0, 0);
`ifdef CTRL_ROLHAS_SATURACAO_EN
        check("overflow_sat", {buffer_secundario, op_ack}, {7'd99, 1'b1});
`else
        check("overflow_rej", {buffer_secundario, estado}, {7'd90, 2'd0});
`endif

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 127)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
